centrosym_vector_stream: RTL and testbench

- Parametrised streaming successor to the 2-element centrosymmetric (unitary ESPRIT) front-end.
- Accepts one snapshot of an N_ANT-element array as a serial stream of complex samples, one element per valid cycle, element 0 first.
- Buffers each snapshot in a ping-pong store. Emits y = Q^H x (unnormalised) serially, so the downstream correlator sees real-valued-friendly data.
- Sits between the channelizer/snapshot formatter and the real correlation-matrix accumulator.

---
 rtl/centrosym_vector_stream.sv | 209 ++++++++++++++++++++
 tb/tb_centrosym_vector_stream.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/centrosym_vector_stream.sv
// Streaming unitary-ESPRIT front end: buffers one N_ANT-element snapshot in a
// ping-pong store and emits y = Q^H x (unnormalised), one row per cycle.
// Rows k < N/2 are x_k + x_(N-1-k); rows k = N/2+p are -j(x_p - x_(N-1-p)).
module centrosym_vector_stream #(
  parameter int DIN_WIDTH = 18,
  parameter int N_ANT     = 4,
  localparam int IDX_WIDTH = $clog2(N_ANT)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sync,
  input  logic signed [DIN_WIDTH-1:0] din_re,
  input  logic signed [DIN_WIDTH-1:0] din_im,
  input  logic                        din_valid,
  output logic signed [DIN_WIDTH:0]   dout_re,
  output logic signed [DIN_WIDTH:0]   dout_im,
  output logic [IDX_WIDTH-1:0]        dout_idx,
  output logic                        dout_valid,
  output logic                        dout_last
);

  generate
    if ((N_ANT < 2) || ((N_ANT % 2) != 0)) begin : g_bad_n_ant
      $error("centrosym_vector_stream: N_ANT must be even and >= 2");
    end
  endgenerate

  localparam logic [IDX_WIDTH-1:0] LP_LAST = IDX_WIDTH'(N_ANT - 1);
  localparam logic [IDX_WIDTH-1:0] LP_HALF = IDX_WIDTH'(N_ANT / 2);
  localparam logic [IDX_WIDTH-1:0] LP_ONE  = IDX_WIDTH'(1);

  typedef enum logic {S_IDLE, S_READ} state_t;

  // Snapshot store: two banks of N_ANT complex samples
  logic signed [DIN_WIDTH-1:0] r_mem_re [2][N_ANT];
  logic signed [DIN_WIDTH-1:0] r_mem_im [2][N_ANT];

  logic [IDX_WIDTH-1:0] r_wr_cnt;
  logic                 r_wr_bank;
  logic [1:0]           r_bank_full;

  state_t               r_state;
  state_t               w_state_next;
  logic [IDX_WIDTH-1:0] r_rd_cnt;
  logic [IDX_WIDTH-1:0] w_rd_cnt_next;
  logic                 r_rd_bank;
  logic                 w_rd_bank_next;
  logic                 w_rd_done;

  logic                 w_wr_fire;
  logic                 w_fill_done;
  logic [1:0]           w_full_eff;

  logic                        w_upper;
  logic [IDX_WIDTH-1:0]        w_idx_a;
  logic [IDX_WIDTH-1:0]        w_idx_b;
  logic signed [DIN_WIDTH:0]   w_a_re;
  logic signed [DIN_WIDTH:0]   w_a_im;
  logic signed [DIN_WIDTH:0]   w_b_re;
  logic signed [DIN_WIDTH:0]   w_b_im;
  logic signed [DIN_WIDTH:0]   w_y_re;
  logic signed [DIN_WIDTH:0]   w_y_im;

  logic signed [DIN_WIDTH:0]   r_dout_re;
  logic signed [DIN_WIDTH:0]   r_dout_im;
  logic [IDX_WIDTH-1:0]        r_dout_idx;
  logic                        r_dout_valid;
  logic                        r_dout_last;

  // sync wins over din_valid: a sample arriving with sync is dropped
  assign w_wr_fire   = din_valid && !sync;
  assign w_fill_done = w_wr_fire && (r_wr_cnt == LP_LAST);

  // A bank counts as full one cycle early when its last element is being
  // written now; this lets readout start without an idle cycle.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_full_eff
      assign w_full_eff[gi] = r_bank_full[gi] || (w_fill_done && (r_wr_bank == 1'(gi)));
    end
  endgenerate

  // Write-side element counter and bank pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
    end else if (sync) begin
      r_wr_cnt <= '0;
    end else if (din_valid) begin
      if (r_wr_cnt == LP_LAST) begin
        r_wr_cnt  <= '0;
        r_wr_bank <= ~r_wr_bank;
      end else begin
        r_wr_cnt <= r_wr_cnt + LP_ONE;
      end
    end
  end

  // Sample storage; contents need no reset since full flags gate every read
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem_re[r_wr_bank][r_wr_cnt] <= din_re;
      r_mem_im[r_wr_bank][r_wr_cnt] <= din_im;
    end
  end

  // Bank full flags: release by the reader, set by the writer (both may occur)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bank_full <= 2'b00;
    end else begin
      if (w_rd_done) begin
        r_bank_full[r_rd_bank] <= 1'b0;
      end
      if (w_fill_done) begin
        r_bank_full[r_wr_bank] <= 1'b1;
      end
    end
  end

  // Read FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rd_cnt  <= '0;
      r_rd_bank <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_rd_cnt  <= w_rd_cnt_next;
      r_rd_bank <= w_rd_bank_next;
    end
  end

  // Read FSM next state: pick the oldest full bank, step rows, chain banks
  always_comb begin
    w_state_next   = r_state;
    w_rd_cnt_next  = r_rd_cnt;
    w_rd_bank_next = r_rd_bank;
    w_rd_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_full_eff) begin
          w_state_next  = S_READ;
          w_rd_cnt_next = '0;
          // The bank not under the write pointer is older when it is full
          w_rd_bank_next = r_bank_full[~r_wr_bank] ? ~r_wr_bank : r_wr_bank;
        end
      end
      S_READ: begin
        if (r_rd_cnt == LP_LAST) begin
          w_rd_done     = 1'b1;
          w_rd_cnt_next = '0;
          if (w_full_eff[~r_rd_bank]) begin
            w_rd_bank_next = ~r_rd_bank;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_rd_cnt_next = r_rd_cnt + LP_ONE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Row k pairs element a with its mirror b = N-1-a and applies Q^H
  always_comb begin
    w_upper = (r_rd_cnt >= LP_HALF);
    w_idx_a = w_upper ? (r_rd_cnt - LP_HALF) : r_rd_cnt;
    w_idx_b = LP_LAST - w_idx_a;
    w_a_re  = {r_mem_re[r_rd_bank][w_idx_a][DIN_WIDTH-1], r_mem_re[r_rd_bank][w_idx_a]};
    w_a_im  = {r_mem_im[r_rd_bank][w_idx_a][DIN_WIDTH-1], r_mem_im[r_rd_bank][w_idx_a]};
    w_b_re  = {r_mem_re[r_rd_bank][w_idx_b][DIN_WIDTH-1], r_mem_re[r_rd_bank][w_idx_b]};
    w_b_im  = {r_mem_im[r_rd_bank][w_idx_b][DIN_WIDTH-1], r_mem_im[r_rd_bank][w_idx_b]};
    if (!w_upper) begin
      w_y_re = w_a_re + w_b_re;
      w_y_im = w_a_im + w_b_im;
    end else begin
      w_y_re = w_a_im - w_b_im;
      w_y_im = w_b_re - w_a_re;
    end
  end

  // Output stage: one register after the read; data holds while invalid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout_re    <= '0;
      r_dout_im    <= '0;
      r_dout_idx   <= '0;
      r_dout_valid <= 1'b0;
      r_dout_last  <= 1'b0;
    end else begin
      r_dout_valid <= (r_state == S_READ);
      r_dout_last  <= (r_state == S_READ) && (r_rd_cnt == LP_LAST);
      if (r_state == S_READ) begin
        r_dout_re  <= w_y_re;
        r_dout_im  <= w_y_im;
        r_dout_idx <= r_rd_cnt;
      end
    end
  end

  assign dout_re    = r_dout_re;
  assign dout_im    = r_dout_im;
  assign dout_idx   = r_dout_idx;
  assign dout_valid = r_dout_valid;
  assign dout_last  = r_dout_last;

endmodule

// File: tb/tb_centrosym_vector_stream.sv
// Directed bench for centrosym_vector_stream (N_ANT=4, DIN_WIDTH=18) with
// hand-computed Q^H x results for each stimulus snapshot.
module tb_centrosym_vector_stream;

  localparam int DW = 18;
  localparam int NA = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 sync = 1'b0;
  logic signed [DW-1:0] din_re = '0;
  logic signed [DW-1:0] din_im = '0;
  logic                 din_valid = 1'b0;
  logic signed [DW:0]   dout_re;
  logic signed [DW:0]   dout_im;
  logic [1:0]           dout_idx;
  logic                 dout_valid;
  logic                 dout_last;

  centrosym_vector_stream #(.DIN_WIDTH(DW), .N_ANT(NA)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .sync       (sync),
    .din_re     (din_re),
    .din_im     (din_im),
    .din_valid  (din_valid),
    .dout_re    (dout_re),
    .dout_im    (dout_im),
    .dout_idx   (dout_idx),
    .dout_valid (dout_valid),
    .dout_last  (dout_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Snapshot inputs and hand-computed outputs
  int x_re [4][4] = '{'{1, 3, 5, 7}, '{10, -3, 0, 2}, '{-100, 20, -7, 1}, '{131071, 0, 0, 131071}};
  int x_im [4][4] = '{'{2, 4, 6, 8}, '{-1, 4, 7, -5}, '{50, -30, 9, 1}, '{-131072, 0, 0, 131071}};
  int y_re [4][4] = '{'{8, 8, -6, -2}, '{12, -3, 4, -3}, '{-99, 13, 49, -39}, '{262142, 0, -262143, 0}};
  int y_im [4][4] = '{'{10, 10, 6, 2}, '{-6, 11, -8, 3}, '{51, -21, 101, -27}, '{-1, 0, 0, 0}};

  typedef struct {
    int re;
    int im;
    int idx;
    int last;
    int cyc;
  } obs_t;
  obs_t q_obs[$];

  int n_total = 0;
  int n_bad   = 0;
  int last_acc = 0;

  // Output monitor: one line per emitted row
  always @(negedge clk) begin
    obs_t o;
    if (dout_valid === 1'b1) begin
      o.re   = int'(dout_re);
      o.im   = int'(dout_im);
      o.idx  = int'(dout_idx);
      o.last = int'(dout_last);
      o.cyc  = cyc;
      q_obs.push_back(o);
      $display("out cyc=%0d idx=%0d re=%0d im=%0d last=%0d", o.cyc, o.idx, o.re, o.im, o.last);
    end
  end

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of input; called #1 after a rising edge
  task automatic put(input int re, input int im, input bit v, input bit s);
    din_re    = DW'(re);
    din_im    = DW'(im);
    din_valid = v;
    sync      = s;
    if (v && !s) last_acc = cyc;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    sync      = 1'b0;
  endtask

  task automatic send_snap(input int s, input bit gaps);
    for (int k = 0; k < NA; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) put(0, 0, 1'b0, 1'b0);
      end
      put(x_re[s][k], x_im[s][k], 1'b1, 1'b0);
    end
  endtask

  // Wait (bounded) for n rows, then let any extra rows show up before counting
  task automatic wait_obs(input int n, input string tag);
    int t;
    t = 0;
    while (q_obs.size() < n && t < 200) begin
      @(posedge clk);
      t++;
    end
    repeat (NA + 4) @(posedge clk);
    #1;
    check_val({tag, " row count"}, q_obs.size(), n);
  endtask

  task automatic check_snap(input string tag, input int base, input int s);
    for (int k = 0; k < NA; k++) begin
      if (base + k < q_obs.size()) begin
        check_val($sformatf("%s y%0d re", tag, k), q_obs[base+k].re, y_re[s][k]);
        check_val($sformatf("%s y%0d im", tag, k), q_obs[base+k].im, y_im[s][k]);
        check_val($sformatf("%s y%0d idx", tag, k), q_obs[base+k].idx, k);
        check_val($sformatf("%s y%0d last", tag, k), q_obs[base+k].last, (k == NA - 1) ? 1 : 0);
      end
    end
  endtask

  task automatic check_contig(input string tag, input int base, input int n);
    for (int i = 1; i < n; i++) begin
      if (base + i < q_obs.size()) begin
        check_val($sformatf("%s gap@%0d", tag, i), q_obs[base+i].cyc - q_obs[base+i-1].cyc, 1);
      end
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, " dout_re"}, dout_re, 0);
    check_val({tag, " dout_im"}, dout_im, 0);
    check_val({tag, " dout_idx"}, dout_idx, 0);
    check_val({tag, " dout_valid"}, dout_valid, 0);
    check_val({tag, " dout_last"}, dout_last, 0);
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic snapshot, latency
    q_obs.delete();
    send_snap(0, 1'b0);
    wait_obs(4, "t1");
    check_snap("t1", 0, 0);
    if (q_obs.size() > 0) check_val("t1 latency", q_obs[0].cyc - last_acc, 2);

    // Three snapshots back to back: 12 contiguous rows
    q_obs.delete();
    send_snap(0, 1'b0);
    send_snap(1, 1'b0);
    send_snap(2, 1'b0);
    wait_obs(12, "t2");
    check_snap("t2 s0", 0, 0);
    check_snap("t2 s1", 4, 1);
    check_snap("t2 s2", 8, 2);
    check_contig("t2", 0, 12);

    // Full-scale inputs
    q_obs.delete();
    send_snap(3, 1'b0);
    wait_obs(4, "t3");
    check_snap("t3", 0, 3);

    // Random input gaps
    q_obs.delete();
    send_snap(1, 1'b1);
    send_snap(2, 1'b1);
    wait_obs(8, "t4");
    check_snap("t4 s1", 0, 1);
    check_snap("t4 s2", 4, 2);
    check_contig("t4 s1", 0, 4);
    check_contig("t4 s2", 4, 4);
    if (q_obs.size() > 4) check_val("t4 latency", q_obs[4].cyc - last_acc, 2);

    // sync after a partial snapshot
    q_obs.delete();
    put(x_re[2][0], x_im[2][0], 1'b1, 1'b0);
    put(x_re[2][1], x_im[2][1], 1'b1, 1'b0);
    put(0, 0, 1'b0, 1'b1);
    send_snap(0, 1'b0);
    wait_obs(4, "t5a");
    check_snap("t5a", 0, 0);

    // sync together with din_valid drops that sample
    q_obs.delete();
    put(x_re[2][0], x_im[2][0], 1'b1, 1'b0);
    put(x_re[2][1], x_im[2][1], 1'b1, 1'b0);
    put(99, 99, 1'b1, 1'b1);
    send_snap(1, 1'b0);
    wait_obs(4, "t5b");
    check_snap("t5b", 0, 1);

    // Reset during readout
    send_snap(0, 1'b0);
    t = 0;
    while (dout_valid !== 1'b1 && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_val("t6 readout seen", dout_valid, 1);
    rst = 1'b1;
    #1;
    check_zero_outputs("t6 rst in read");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset during a partial write
    put(x_re[3][0], x_im[3][0], 1'b1, 1'b0);
    put(x_re[3][1], x_im[3][1], 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check_zero_outputs("t6 rst in write");
    @(posedge clk);
    #1;
    rst = 1'b0;
    q_obs.delete();
    send_snap(2, 1'b0);
    wait_obs(4, "t6");
    check_snap("t6", 0, 2);
    if (q_obs.size() > 0) check_val("t6 latency", q_obs[0].cyc - last_acc, 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
